// File: rtl/pipeline_defs.sv
// Shared definitions for the RV32IM pipeline stages.
// Fetch FSM encoding, bubble word and PC-source selector.
package pipeline_defs;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP = 2'd0,
        PC_SEQ  = 2'd1,
        PC_TGT  = 2'd2,
        PC_TGTQ = 2'd3
    } pc_sel_t;

    function automatic logic [XLEN-1:0] align_word(
        input logic [XLEN-1:0] addr
    );
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Fetch-stage program counter with next-PC selection.
// Redirect targets are forced to word alignment here.
module if_pc_reg
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  pc_sel_t     pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] target_q,
    output logic [31:0] pc,
    output logic [31:0] aligned_target
);

    logic [31:0] pc_next;

    assign aligned_target = align_word(branch_target);

    always_comb begin
        pc_next = pc;
        unique case (pc_sel)
            PC_KEEP: pc_next = pc;
            PC_SEQ:  pc_next = pc + 32'd4;
            PC_TGT:  pc_next = aligned_target;
            PC_TGTQ: pc_next = target_q;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the imem handshake and
// presents PC/instruction (or a bubble) to IF/ID.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = pipeline_defs::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_defs::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_SRC_SEL,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] OUT_PC,
    output logic [31:0] OUT_INSTRUCTION,
    output logic        FETCH_BUSYWAIT
);

    import pipeline_defs::*;

    fetch_state_t state;
    fetch_state_t state_next;
    pc_sel_t      pc_sel;
    logic [31:0]  pc;
    logic [31:0]  aligned_target;
    logic [31:0]  target_q;
    logic [31:0]  instr_buf;
    logic         buf_load;
    logic         tq_load;

    if_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .CLK           (CLK),
        .RESET         (RESET),
        .pc_sel        (pc_sel),
        .branch_target (BRANCH_TARGET),
        .target_q      (target_q),
        .pc            (pc),
        .aligned_target(aligned_target)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= FETCH;
            instr_buf <= NOP_INSTR;
            target_q  <= '0;
        end else begin
            state <= state_next;
            if (buf_load) instr_buf <= IMEM_READDATA;
            if (tq_load)  target_q  <= aligned_target;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (PC_SRC_SEL && IMEM_BUSYWAIT)
                    state_next = DRAIN;
                else if (!PC_SRC_SEL && !IMEM_BUSYWAIT && STALL)
                    state_next = HOLD;
            end
            HOLD: begin
                if (PC_SRC_SEL || !STALL)
                    state_next = FETCH;
            end
            DRAIN: begin
                if (!IMEM_BUSYWAIT)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        IMEM_READ       = 1'b0;
        IMEM_ADDRESS    = pc;
        OUT_PC          = pc;
        OUT_INSTRUCTION = NOP_INSTR;
        FETCH_BUSYWAIT  = 1'b0;
        pc_sel          = PC_KEEP;
        buf_load        = 1'b0;
        tq_load         = 1'b0;
        case (state)
            FETCH: begin
                IMEM_READ      = 1'b1;
                FETCH_BUSYWAIT = IMEM_BUSYWAIT;
                if (!PC_SRC_SEL) OUT_INSTRUCTION = IMEM_READDATA;
                if (PC_SRC_SEL) begin
                    if (IMEM_BUSYWAIT) tq_load = 1'b1;
                    else               pc_sel  = PC_TGT;
                end else if (!IMEM_BUSYWAIT) begin
                    if (STALL) buf_load = 1'b1;
                    else       pc_sel   = PC_SEQ;
                end
            end
            HOLD: begin
                if (!PC_SRC_SEL) OUT_INSTRUCTION = instr_buf;
                if (PC_SRC_SEL)  pc_sel = PC_TGT;
                else if (!STALL) pc_sel = PC_SEQ;
            end
            DRAIN: begin
                // old address stays on the bus until the read retires
                IMEM_READ      = 1'b1;
                FETCH_BUSYWAIT = 1'b1;
                tq_load        = PC_SRC_SEL;
                if (!IMEM_BUSYWAIT)
                    pc_sel = PC_SRC_SEL ? PC_TGT : PC_TGTQ;
            end
            default: ;
        endcase
        if (!RESET) begin
            IMEM_READ       = 1'b0;
            OUT_INSTRUCTION = NOP_INSTR;
            FETCH_BUSYWAIT  = 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed
// scenarios plus randomized traffic against a behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        src;
    logic [31:0] tgt;
    logic        stall;
    logic [31:0] rdata;
    logic        busy;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_bw;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_buf;
    logic [31:0] m_tq;
    bit          m_held;
    bit          m_pending;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h00A0_0093 : a;
    endfunction

    assign rdata = mem_word(imem_addr);

    instruction_fetch_unit dut (
        .CLK            (clk),
        .RESET          (rst),
        .PC_SRC_SEL     (src),
        .BRANCH_TARGET  (tgt),
        .STALL          (stall),
        .IMEM_READDATA  (rdata),
        .IMEM_BUSYWAIT  (busy),
        .IMEM_READ      (imem_read),
        .IMEM_ADDRESS   (imem_addr),
        .OUT_PC         (out_pc),
        .OUT_INSTRUCTION(out_instr),
        .FETCH_BUSYWAIT (fetch_bw)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        logic [31:0] t;
        if (!rst) begin
            m_pc      = RPC;
            m_buf     = NOP;
            m_tq      = 32'h0;
            m_held    = 1'b0;
            m_pending = 1'b0;
        end else begin
            t = tgt & 32'hFFFF_FFFC;
            if (m_pending) begin
                if (src) m_tq = t;
                if (!busy) begin
                    m_pc      = m_tq;
                    m_pending = 1'b0;
                end
            end else if (m_held) begin
                if (src) begin
                    m_pc   = t;
                    m_held = 1'b0;
                end else if (!stall) begin
                    m_pc   = m_pc + 32'd4;
                    m_held = 1'b0;
                end
            end else if (src) begin
                if (busy) begin
                    m_pending = 1'b1;
                    m_tq      = t;
                end else begin
                    m_pc = t;
                end
            end else if (!busy) begin
                if (stall) begin
                    m_held = 1'b1;
                    m_buf  = mem_word(m_pc);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!rst) begin
                chk("rst_read", {31'b0, imem_read}, 32'd0);
                chk("rst_addr", imem_addr, RPC);
                chk("rst_pc", out_pc, RPC);
                chk("rst_instr", out_instr, NOP);
                chk("rst_bw", {31'b0, fetch_bw}, 32'd0);
            end else if (m_pending) begin
                chk("drain_read", {31'b0, imem_read}, 32'd1);
                chk("drain_addr", imem_addr, m_pc);
                chk("drain_instr", out_instr, NOP);
                chk("drain_bw", {31'b0, fetch_bw}, 32'd1);
            end else if (m_held) begin
                chk("hold_read", {31'b0, imem_read}, 32'd0);
                chk("hold_pc", out_pc, m_pc);
                chk("hold_instr", out_instr, src ? NOP : m_buf);
                chk("hold_bw", {31'b0, fetch_bw}, 32'd0);
            end else begin
                chk("fetch_read", {31'b0, imem_read}, 32'd1);
                chk("fetch_addr", imem_addr, m_pc);
                chk("fetch_pc", out_pc, m_pc);
                chk("fetch_instr", out_instr,
                    src ? NOP : mem_word(m_pc));
                chk("fetch_bw", {31'b0, fetch_bw}, {31'b0, busy});
            end
        end
    end

    task automatic step(input bit s, input logic [31:0] t,
                        input bit st, input bit b);
        @(posedge clk);
        #1;
        src   = s;
        tgt   = t;
        stall = st;
        busy  = b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        src   = 1'b0;
        stall = 1'b0;
        busy  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        src    = 1'b0;
        tgt    = 32'h0;
        stall  = 1'b0;
        busy   = 1'b0;
        cmp_en = 1'b1;
        #3;
        chk("lit_rst_read", {31'b0, imem_read}, 32'd0);
        chk("lit_rst_instr", out_instr, 32'h0000_0013);
        chk("lit_rst_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("lit_seq0", out_pc, 32'h0);
        step(0, 0, 0, 0);
        chk("lit_seq4", out_pc, 32'h4);
        step(0, 0, 0, 0);
        chk("lit_seq8", out_pc, 32'h8);
        step(0, 0, 0, 0);
        chk("lit_seq12", out_pc, 32'hC);
        chk("lit_seq_bw", {31'b0, fetch_bw}, 32'd0);

        do_reset();
        step(0, 0, 1, 0);
        chk("lit_stall_fetch", out_instr, 32'h00A0_0093);
        step(0, 0, 1, 0);
        chk("lit_hold_read", {31'b0, imem_read}, 32'd0);
        chk("lit_hold_instr", out_instr, 32'h00A0_0093);
        chk("lit_hold_pc", out_pc, 32'h4);
        step(0, 0, 0, 0);
        chk("lit_hold_rel_pc", out_pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("lit_busy_bw", {31'b0, fetch_bw}, 32'd1);
            chk("lit_busy_addr", imem_addr, 32'h8);
        end
        step(0, 0, 0, 0);
        chk("lit_busy_done_pc", out_pc, 32'h8);
        step(0, 0, 0, 0);
        chk("lit_after_busy", out_pc, 32'hC);

        step(1, 32'h103, 0, 1);
        chk("lit_redir_nop", out_instr, 32'h0000_0013);
        chk("lit_redir_addr", imem_addr, 32'h10);
        step(0, 0, 0, 1);
        chk("lit_drain_addr", imem_addr, 32'h10);
        chk("lit_drain_instr", out_instr, 32'h0000_0013);
        step(0, 0, 0, 0);
        chk("lit_drain_end_addr", imem_addr, 32'h10);
        step(0, 0, 1, 0);
        chk("lit_tgt_addr", imem_addr, 32'h100);

        step(1, 32'h40, 1, 0);
        chk("lit_hold_redir", out_instr, 32'h0000_0013);
        step(0, 0, 0, 0);
        chk("lit_hold_redir_pc", out_pc, 32'h40);
        chk("lit_hold_redir_rd", {31'b0, imem_read}, 32'd1);

        step(1, 32'h200, 0, 1);
        step(0, 0, 0, 1);
        chk("lit_drain2_bw", {31'b0, fetch_bw}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("lit_mid_rst_read", {31'b0, imem_read}, 32'd0);
        chk("lit_mid_rst_pc", out_pc, 32'h0);
        chk("lit_mid_rst_instr", out_instr, 32'h0000_0013);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        busy = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0);
        chk("lit_tq_discard", out_pc, 32'h4);

        step(1, 32'hFFFF_FFFF, 0, 0);
        step(0, 0, 0, 0);
        chk("lit_align_top", out_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("lit_wrap", out_pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst   = (rst == 1'b0) ? 1'b1 : ($urandom_range(0, 199) != 0);
            src   = ($urandom_range(0, 5) == 0);
            tgt   = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            busy  = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
